// File: rtl/rr_arb4_dec.sv
// rtl/rr_arb4_dec.sv - four-requester round-robin arbiter with registered 2:4 grant decode
module rr_arb4_dec #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_SAT   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] HOLD_ONE   = CNT_W'(1);
   localparam bit               LIMIT_ON   = (MAX_HOLD != 0);

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [3:0]       gnt_q, gnt_d;
   logic             timeout_q, timeout_d;

   logic [1:0]       winner;
   logic [1:0]       cand;
   logic             owner_req;
   logic             limit_hit;

   // Scan from the highest offset down so the lowest offset from ptr wins.
   always_comb begin
      winner = ptr_q;
      cand   = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_q + 2'(k);
         if (req[cand]) begin
            winner = cand;
         end
      end
   end

   assign owner_req = req[idx_q];
   assign limit_hit = LIMIT_ON && (hold_q == HOLD_LIMIT);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      hold_d    = hold_q;
      gnt_d     = gnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               idx_d   = winner;
               gnt_d   = 4'b0001 << winner;
               hold_d  = HOLD_ONE;
            end
         end
         GRANT: begin
            if (!owner_req || limit_hit) begin
               state_d   = IDLE;
               gnt_d     = 4'b0000;
               hold_d    = '0;
               ptr_d     = idx_q + 2'd1;
               timeout_d = owner_req & limit_hit;
            end else if (hold_q != HOLD_SAT) begin
               hold_d = hold_q + HOLD_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= 2'd0;
         idx_q     <= 2'd0;
         hold_q    <= '0;
         gnt_q     <= 4'b0000;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = (state_q == GRANT);
   assign timeout   = timeout_q;

endmodule
